// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receive and transmit paths.
// Holds the controller state encoding and the address/byte widths.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;
    localparam logic [I2C_BYTE_W-1:0] GEN_CALL_ADDR = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } i2c_slv_state_e;

endpackage

// File: rtl/i2c_bus_events.sv
// I2C bus event decoder: SCL edges plus START/STOP from current and previous samples.
// Shared by the slave receive and transmit controllers.
module i2c_bus_events (
    input  logic FPGA_clk,
    input  logic rst,
    input  logic SCL,
    input  logic SCL_prev,
    input  logic SDA,
    input  logic SDA_prev,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    // Clock and reset stay on the port list so every user wires this block the same way.
    logic unused_clk_rst;
    assign unused_clk_rst = FPGA_clk ^ rst;

    assign scl_rise = SCL & ~SCL_prev;
    assign scl_fall = ~SCL & SCL_prev;
    assign start    = SCL & SCL_prev & SDA_prev & ~SDA;
    assign stop     = SCL & SCL_prev & ~SDA_prev & SDA;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave receive-path controller: address decode, ACK drive, data decoder gating.
// Define I2C_GENERAL_CALL_EN to also ACK general-call writes and expose gc_hit.
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h2A,
    parameter int                    NUM_BYTES  = 6
) (
    input  logic                           FPGA_clk,
    input  logic                           rst,
    input  logic                           SCL,
    input  logic                           SCL_prev,
    input  logic                           SDA,
    input  logic                           SDA_prev,
    output logic                           SDA_down,
    output logic                           dec_en,
    output logic                           dec_clr,
    output logic                           addr_match,
    output logic                           rw_bit,
    output logic [$clog2(NUM_BYTES+1)-1:0] byte_cnt,
    output logic                           busy,
    output logic                           overflow
`ifdef I2C_GENERAL_CALL_EN
    ,
    output logic                           gc_hit
`endif
);

    localparam int CW = $clog2(NUM_BYTES + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(NUM_BYTES);

    i2c_slv_state_e        state_q;
    logic [I2C_BYTE_W-1:0] shift_q;
    logic [I2C_BYTE_W-1:0] shift_d;
    logic [3:0]            bit_cnt_q;
    logic [CW-1:0]         byte_cnt_q;
    logic                  sda_down_q;
    logic                  dec_en_q;
    logic                  dec_clr_q;
    logic                  addr_match_q;
    logic                  rw_bit_q;
    logic                  overflow_q;

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic eighth_fall;
    logic ack_fall;
    logic gc_addr;
    logic addr_hit;

    i2c_bus_events u_events (
        .FPGA_clk (FPGA_clk),
        .rst      (rst),
        .SCL      (SCL),
        .SCL_prev (SCL_prev),
        .SDA      (SDA),
        .SDA_prev (SDA_prev),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign shift_d     = {shift_q[I2C_BYTE_W-2:0], SDA};
    assign eighth_fall = scl_fall && (bit_cnt_q == 4'd8);
    assign ack_fall    = scl_fall && (bit_cnt_q == 4'd1);

`ifdef I2C_GENERAL_CALL_EN
    logic gc_hit_q;

    assign gc_addr = (shift_q == GEN_CALL_ADDR);
    assign gc_hit  = gc_hit_q;

    always_ff @(posedge FPGA_clk) begin
        if (rst || start) begin
            gc_hit_q <= 1'b0;
        end else if (state_q == S_ADDR && eighth_fall && gc_addr) begin
            gc_hit_q <= 1'b1;
        end
    end
`else
    assign gc_addr = 1'b0;
`endif

    assign addr_hit = ((shift_q[I2C_BYTE_W-1:1] == SLAVE_ADDR) && !shift_q[0])
                      || gc_addr;

    always_ff @(posedge FPGA_clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            sda_down_q   <= 1'b0;
            dec_en_q     <= 1'b0;
            dec_clr_q    <= 1'b0;
            addr_match_q <= 1'b0;
            rw_bit_q     <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            dec_clr_q <= 1'b0;
            if (stop) begin
                state_q      <= S_IDLE;
                sda_down_q   <= 1'b0;
                dec_en_q     <= 1'b0;
                addr_match_q <= 1'b0;
            end else if (start) begin
                state_q      <= S_ADDR;
                bit_cnt_q    <= '0;
                byte_cnt_q   <= '0;
                overflow_q   <= 1'b0;
                dec_clr_q    <= 1'b1;
                sda_down_q   <= 1'b0;
                dec_en_q     <= 1'b0;
                addr_match_q <= 1'b0;
            end else begin
                if (scl_rise && bit_cnt_q < 4'd8) begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
                unique case (state_q)
                    S_IDLE: begin
                    end
                    S_ADDR: begin
                        if (scl_rise) begin
                            shift_q <= shift_d;
                        end
                        if (eighth_fall) begin
                            bit_cnt_q <= '0;
                            if (addr_hit) begin
                                sda_down_q   <= 1'b1;
                                addr_match_q <= 1'b1;
                                rw_bit_q     <= shift_q[0];
                                state_q      <= S_ADDR_ACK;
                            end else begin
                                state_q <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (ack_fall) begin
                            sda_down_q <= 1'b0;
                            dec_en_q   <= 1'b1;
                            bit_cnt_q  <= '0;
                            state_q    <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (eighth_fall) begin
                            dec_en_q  <= 1'b0;
                            bit_cnt_q <= '0;
                            if (byte_cnt_q < MAX_CNT) begin
                                sda_down_q <= 1'b1;
                                byte_cnt_q <= byte_cnt_q + CW'(1);
                                state_q    <= S_DATA_ACK;
                            end else begin
                                overflow_q <= 1'b1;
                                state_q    <= S_IGNORE;
                            end
                        end
                    end
                    S_DATA_ACK: begin
                        if (ack_fall) begin
                            sda_down_q <= 1'b0;
                            bit_cnt_q  <= '0;
                            if (byte_cnt_q == MAX_CNT) begin
                                state_q <= S_IGNORE;
                            end else begin
                                dec_en_q <= 1'b1;
                                state_q  <= S_DATA;
                            end
                        end
                    end
                    S_IGNORE: begin
                        sda_down_q <= 1'b0;
                        dec_en_q   <= 1'b0;
                        // A full byte arriving after the last accepted one is an overflow.
                        if (eighth_fall) begin
                            bit_cnt_q <= '0;
                            if (addr_match_q && byte_cnt_q == MAX_CNT) begin
                                overflow_q <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign SDA_down   = sda_down_q;
    assign dec_en     = dec_en_q;
    assign dec_clr    = dec_clr_q;
    assign addr_match = addr_match_q;
    assign rw_bit     = rw_bit_q;
    assign byte_cnt   = byte_cnt_q;
    assign busy       = (state_q != S_IDLE);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: bus-level master driver, wired-AND SDA,
// a behavioural data decoder and a per-transaction expectation model.
module tb_i2c_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCL = 1'b1;
    logic       SCL_prev = 1'b1;
    logic       SDA = 1'b1;
    logic       SDA_prev = 1'b1;
    logic       SDA_down;
    logic       dec_en;
    logic       dec_clr;
    logic       addr_match;
    logic       rw_bit;
    logic [2:0] byte_cnt;
    logic       busy;
    logic       overflow;
`ifdef I2C_GENERAL_CALL_EN
    logic       gc_hit;
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    i2c_slave_ctrl dut (
        .FPGA_clk   (clk),
        .rst        (rst),
        .SCL        (SCL),
        .SCL_prev   (SCL_prev),
        .SDA        (SDA),
        .SDA_prev   (SDA_prev),
        .SDA_down   (SDA_down),
        .dec_en     (dec_en),
        .dec_clr    (dec_clr),
        .addr_match (addr_match),
        .rw_bit     (rw_bit),
        .byte_cnt   (byte_cnt),
        .busy       (busy),
        .overflow   (overflow)
`ifdef I2C_GENERAL_CALL_EN
        ,
        .gc_hit     (gc_hit)
`endif
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         passed = 0;
    int         sda_viol = 0;
    int         den_viol = 0;
    int         clr_cnt = 0;
    int         dbits = 0;
    logic       ack_slot = 1'b0;
    logic       den_last = 1'b0;
    logic       den_seen = 1'b0;
    logic [7:0] dsh = 8'h00;
    logic [7:0] dec_q[$];
    logic [7:0] tx_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One FPGA_clk: observe the settled outputs, then drive the next bus sample.
    task automatic cyc(input logic s, input logic d);
        @(negedge clk);
        if (SDA_down === 1'b1 && SCL && !ack_slot) sda_viol++;
        if (dec_en === 1'b1 && ack_slot) den_viol++;
        if (dec_en === 1'b1) den_seen = 1'b1;
        if (dec_clr === 1'b1) begin
            clr_cnt++;
            dbits = 0;
        end else if (den_last && SCL && !SCL_prev) begin
            dsh = {dsh[6:0], SDA};
            dbits++;
            if (dbits == 8) begin
                dec_q.push_back(dsh);
                dbits = 0;
            end
        end
        den_last = (dec_en === 1'b1);
        SCL_prev = SCL;
        SDA_prev = SDA;
        SCL = s;
        SDA = d & ~(SDA_down === 1'b1);
    endtask

    task automatic send_start();
        if (SCL === 1'b0) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic send_stop();
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
    endtask

    task automatic send_bit(input logic d);
        cyc(1'b0, d);
        cyc(1'b1, d);
        cyc(1'b1, d);
        cyc(1'b0, d);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_slot = 1'b1;
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        ack = (SDA === 1'b0);
        cyc(1'b0, 1'b1);
        ack_slot = 1'b0;
    endtask

    function automatic bit addr_ok(input logic [7:0] a);
        return (a == 8'h54) || (GC_EN && a == 8'h00);
    endfunction

    // Full write transaction of tx_q to address byte a, checked against the rules.
    task automatic txn(input logic [7:0] a);
        logic ack;
        bit   m;
        int   n;
        int   nacc;
        int   c0;
        logic [7:0] got;
        m    = addr_ok(a);
        n    = tx_q.size();
        nacc = m ? ((n < 6) ? n : 6) : 0;
        dec_q.delete();
        den_seen = 1'b0;
        sda_viol = 0;
        den_viol = 0;
        c0 = clr_cnt;
        send_start();
        send_byte(a, ack);
        chk("addr_ack", 32'(ack), 32'(m));
        chk("addr_match", 32'(addr_match), 32'(m));
        chk("busy_txn", 32'(busy), 32'(1));
        if (m) chk("rw_bit", 32'(rw_bit), 32'(0));
        for (int i = 0; i < n; i++) begin
            send_byte(tx_q[i], ack);
            chk("data_ack", 32'(ack), 32'(m && i < 6));
        end
        chk("overflow", 32'(overflow), 32'(m && n > 6));
`ifdef I2C_GENERAL_CALL_EN
        chk("gc_hit", 32'(gc_hit), 32'(m && a == 8'h00));
`endif
        send_stop();
        chk("byte_cnt", 32'(byte_cnt), 32'(nacc));
        chk("busy_idle", 32'(busy), 32'(0));
        chk("dec_en_off", 32'(dec_en), 32'(0));
        chk("sda_released", 32'(SDA_down), 32'(0));
        chk("dec_en_seen", 32'(den_seen), 32'(m));
        chk("dec_count", 32'(dec_q.size()), 32'(nacc));
        for (int i = 0; i < nacc; i++) begin
            got = (i < dec_q.size()) ? dec_q[i] : 8'hxx;
            chk("dec_byte", 32'(got), 32'(tx_q[i]));
        end
        chk("dec_clr_pulses", 32'(clr_cnt - c0), 32'(1));
        chk("sda_down_scl_hi", 32'(sda_viol), 32'(0));
        chk("dec_en_in_ack", 32'(den_viol), 32'(0));
    endtask

    initial begin
        logic       ack;
        logic [7:0] a;
        logic [7:0] b;
        int         c0;

        cyc(1'b1, 1'b1);
        rst = 1'b0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk("rst_sda_down", 32'(SDA_down), 32'(0));
        chk("rst_dec_en", 32'(dec_en), 32'(0));
        chk("rst_dec_clr", 32'(dec_clr), 32'(0));
        chk("rst_addr_match", 32'(addr_match), 32'(0));
        chk("rst_rw_bit", 32'(rw_bit), 32'(0));
        chk("rst_byte_cnt", 32'(byte_cnt), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));

        tx_q = '{8'hA5, 8'h3C, 8'h0F};
        txn(8'h54);
        tx_q = '{8'h99};
        txn(8'h56);
        tx_q.delete();
        txn(8'h55);
        tx_q.delete();
        for (int i = 0; i < 7; i++) tx_q.push_back(8'($urandom));
        txn(8'h54);

        // Partial byte aborted by a repeated START.
        dec_q.delete();
        c0 = clr_cnt;
        send_start();
        send_byte(8'h54, ack);
        chk("rs_addr_ack", 32'(ack), 32'(1));
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        send_start();
        chk("rs_byte_cnt_clr", 32'(byte_cnt), 32'(0));
        send_byte(8'h54, ack);
        chk("rs_addr_ack2", 32'(ack), 32'(1));
        b = 8'($urandom);
        send_byte(b, ack);
        chk("rs_data_ack", 32'(ack), 32'(1));
        send_stop();
        chk("rs_byte_cnt", 32'(byte_cnt), 32'(1));
        chk("rs_dec_clr", 32'(clr_cnt - c0), 32'(2));
        chk("rs_dec_count", 32'(dec_q.size()), 32'(1));
        chk("rs_dec_byte", 32'((dec_q.size() > 0) ? dec_q[0] : 8'hxx), 32'(b));

        tx_q = '{8'h12, 8'h34};
        txn(8'h00);

        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(0, 4))
                0: a = 8'h54;
                1: a = 8'h56;
                2: a = 8'h55;
                3: a = 8'h00;
                default: a = 8'($urandom);
            endcase
            tx_q.delete();
            for (int i = 0; i < int'($urandom_range(0, 8)); i++) begin
                tx_q.push_back(8'($urandom));
            end
            txn(a);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
- Transaction controller for the I2C slave receive path.
- Detects START, repeated START and STOP, and decodes the 7-bit address plus R/W byte.
- Drives the slave ACK (SDA_down) and gates and clears the data-in decoder (dec_en/dec_clr) so that the decoder only sees data bits of an addressed write.
- Sits between the synchronised SCL/SDA samples and data_in_top_level; all SCL/SDA handling is sampled on FPGA_clk.

Parameters:
- SLAVE_ADDR, 7'h2A, 7-bit slave address matched against the first byte after START.
- NUM_BYTES, 6, maximum data bytes accepted per transaction; must match the decoder.

Ports:
- FPGA_clk  in  1  system clock; SCL/SDA are oversampled by it.
- rst  in  1  synchronous active-high reset.
- SCL  in  1  synchronised SCL sample.
- SCL_prev  in  1  SCL sample from the previous FPGA_clk.
- SDA  in  1  synchronised SDA sample.
- SDA_prev  in  1  SDA sample from the previous FPGA_clk.
- SDA_down  out  1  1 = pull SDA low (ACK).
- dec_en  out  1  enable to data_in_top_level; high only while data bits are being received.
- dec_clr  out  1  one-cycle pulse that clears the decoder at every START.
- addr_match  out  1  high from address ACK until STOP/START.
- rw_bit  out  1  R/W bit latched from the address byte.
- byte_cnt  out  $clog2(NUM_BYTES+1)  data bytes ACKed in the current transaction.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky flag: master sent more than NUM_BYTES bytes; cleared at START.

Behaviour:
- Events, each combinational from the current and previous samples:
  - scl_rise = SCL & ~SCL_prev
  - scl_fall = ~SCL & SCL_prev
  - start = SCL & SCL_prev & SDA_prev & ~SDA
  - stop = SCL & SCL_prev & ~SDA_prev & SDA
- Priority: rst > stop > start > scl_rise/scl_fall.
- All outputs are registered and update one FPGA_clk after the triggering event.
- Reset: state = IDLE; SDA_down, dec_en, dec_clr, addr_match, rw_bit, overflow all 0; byte_cnt = 0; bit counter = 0.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- start (any state, including repeated START):
  - go to ADDR; clear bit counter, byte_cnt and overflow; pulse dec_clr; drop SDA_down, dec_en and addr_match.
- stop (any state): go to IDLE; drop SDA_down and dec_en; byte_cnt is held for readout until the next START.
- ADDR:
  - Shift SDA into an 8-bit register MSB-first on each scl_rise.
  - On the scl_fall after the 8th rise:
    - If addr[7:1] == SLAVE_ADDR and bit0 == 0: assert SDA_down, set addr_match, latch rw_bit, go to ADDR_ACK.
    - Otherwise (mismatch, or R/W = 1 since the read path is absent): leave SDA released and go to IGNORE.
- ADDR_ACK: hold SDA_down through the 9th SCL pulse. On the following scl_fall, release SDA_down, raise dec_en, reset the bit counter and go to DATA.
- DATA:
  - Count scl_rise events.
  - On the scl_fall after the 8th rise, drop dec_en and go to DATA_ACK.
  - If byte_cnt < NUM_BYTES: assert SDA_down and increment byte_cnt.
  - Otherwise: set overflow, NACK (SDA released) and go to IGNORE instead.
- DATA_ACK: on the next scl_fall, release SDA_down and raise dec_en (DATA). If byte_cnt == NUM_BYTES, drop dec_en and go to IGNORE; a further byte is then NACKed by the IGNORE rule.
- IGNORE: SDA_down = 0 and dec_en = 0; leave only on start or stop.
- SDA_down is never asserted while SCL is high except during the 9th (ACK) clock.
- dec_en is never high during ACK clocks.
- A STOP mid-byte discards the partial byte; byte_cnt is not incremented.

Optional Feature:
- Macro: I2C_GENERAL_CALL_EN.
- Defined: an address byte of 8'h00 (general call, write) is also ACKed and handled exactly like a SLAVE_ADDR write. addr_match is set, and an extra output gc_hit (1 bit, reset 0, cleared at START) is high for the transaction.
- Undefined: 8'h00 is treated as a mismatch (IGNORE), and the gc_hit port does not exist.

Decomposition:
- Package i2c_pkg holds:
  - the state enum i2c_slv_state_e;
  - localparams I2C_ADDR_W = 7, I2C_BYTE_W = 8, GEN_CALL_ADDR = 8'h00.
- Sub-module i2c_bus_events takes FPGA_clk, rst, SCL, SCL_prev, SDA and SDA_prev, and produces the scl_rise, scl_fall, start and stop pulses. It is reused by the slave transmit path.

Test Plan:
- Reset held 1 cycle, then idle bus (SCL = SDA = 1) -> all outputs 0, busy = 0.
- START, address byte 8'h54 (0x2A, write), 3 data bytes 8'hA5, 8'h3C, 8'h0F, STOP:
  - required: SDA_down low on each of 4 ACK clocks; dec_en high only during data bits; byte_cnt = 3 after STOP; decoder nibbles 5, C, F.
- START, address 8'h56 (wrong address), 1 byte -> SDA_down never asserted, dec_en = 0, state IGNORE until STOP.
- START, address 8'h55 (R/W = 1) -> NACK, addr_match = 0, IGNORE.
- START, 8'h54, 7 data bytes -> bytes 1-6 ACKed, 7th NACKed, overflow = 1, byte_cnt = 6.
- START, 8'h54, 4 data bits, then repeated START, 8'h54, 1 byte, STOP:
  - required: dec_clr pulses twice; byte_cnt = 1; partial byte discarded.
  - With I2C_GENERAL_CALL_EN defined, address 8'h00 additionally gives ACK and gc_hit = 1.
